// File: rtl/lab_tt_scanner.sv
// rtl/lab_tt_scanner.sv - sweeps all N_IN-bit vectors into a combinational DUT and checks its truth table
// Optional first-mismatch capture ports are enabled by defining LAB_SCAN_FIRST_ERR_EN.
module lab_tt_scanner #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_tt,
  output logic [N_IN-1:0]      stim,
  input  logic                 resp,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic [N_IN:0]        err_cnt,
  output logic                 pass
`ifdef LAB_SCAN_FIRST_ERR_EN
  ,
  output logic [N_IN-1:0]      first_err,
  output logic                 first_err_vld
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0]      SETTLE_V = 4'(SETTLE);
  localparam logic [N_IN-1:0] STIM_MAX = {N_IN{1'b1}};

  state_t              state, state_nxt;
  logic [3:0]          settle;
  logic [2**N_IN-1:0]  exp_q;
  logic                sample, last, mismatch;

  assign sample   = (settle == SETTLE_V);
  assign last     = sample && (stim == STIM_MAX);
  assign mismatch = (resp != exp_q[stim]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRIVE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim    <= '0;
      settle  <= '0;
      exp_q   <= '0;
      tt      <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
`ifdef LAB_SCAN_FIRST_ERR_EN
      first_err     <= '0;
      first_err_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          stim <= '0;
          if (start) begin
            settle  <= '0;
            exp_q   <= exp_tt;
            tt      <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
`ifdef LAB_SCAN_FIRST_ERR_EN
            first_err     <= '0;
            first_err_vld <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          if (sample) begin
            settle     <= '0;
            tt[stim]   <= resp;
            if (mismatch) err_cnt <= err_cnt + 1'b1;
`ifdef LAB_SCAN_FIRST_ERR_EN
            if (mismatch && !first_err_vld) begin
              first_err     <= stim;
              first_err_vld <= 1'b1;
            end
`endif
            // pass must already reflect the final sample when DONE is shown
            if (stim == STIM_MAX) pass <= (err_cnt == '0) && !mismatch;
            else                  stim <= stim + 1'b1;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        DONE:    stim <= '0;
        default: stim <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lab_tt_scanner.sv
// tb/tb_lab_tt_scanner.sv - randomized and directed self-checking bench for lab_tt_scanner
module tb_lab_tt_scanner;

  localparam int N     = 4;
  localparam int S     = 2;
  localparam int V     = 16;
  localparam int SWEEP = V * (S + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [V-1:0]  exp_tt;
  logic [N-1:0]  stim;
  logic          resp;
  logic          busy, done, pass;
  logic [V-1:0]  tt;
  logic [N:0]    err_cnt;
`ifdef LAB_SCAN_FIRST_ERR_EN
  logic [N-1:0]  first_err;
  logic          first_err_vld;
  logic [N-2:0]  first_err3;
  logic          first_err_vld3;
`endif

  logic          start3;
  logic [7:0]    exp3;
  logic [2:0]    stim3;
  logic          resp3, busy3, done3, pass3;
  logic [7:0]    tt3;
  logic [3:0]    err3;

  int            mode;
  logic [V-1:0]  rtab;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign resp  = (mode == 0) ? stim[0] : (mode == 1) ? 1'b0 : rtab[stim];
  assign resp3 = stim3[2] & stim3[1];

  lab_tt_scanner #(.N_IN(N), .SETTLE(S)) u_dut (
    .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt), .stim(stim), .resp(resp),
    .busy(busy), .done(done), .tt(tt), .err_cnt(err_cnt), .pass(pass)
`ifdef LAB_SCAN_FIRST_ERR_EN
    , .first_err(first_err), .first_err_vld(first_err_vld)
`endif
  );

  lab_tt_scanner #(.N_IN(3), .SETTLE(0)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .exp_tt(exp3), .stim(stim3), .resp(resp3),
    .busy(busy3), .done(done3), .tt(tt3), .err_cnt(err3), .pass(pass3)
`ifdef LAB_SCAN_FIRST_ERR_EN
    , .first_err(first_err3), .first_err_vld(first_err_vld3)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic resp_model(input int v);
    if (mode == 0) return v[0];
    if (mode == 1) return 1'b0;
    return rtab[v];
  endfunction

  // Reference: elapsed cycles since acceptance plus results computed from whole tables.
  bit           m_active;
  int           m_cnt;
  logic [V-1:0] m_tt;
  int           m_err;
  logic [N-1:0] m_first;
  bit           m_fvld;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_cnt    = 0;
    end else if ((!m_active || m_cnt == SWEEP + 1) && start) begin
      m_active = 1;
      m_cnt    = 0;
      m_fvld   = 0;
      m_first  = '0;
      for (int v = 0; v < V; v++) m_tt[v] = resp_model(v);
      m_err = $countones(m_tt ^ exp_tt);
      for (int v = V - 1; v >= 0; v--)
        if (m_tt[v] != exp_tt[v]) begin
          m_first = N'(v);
          m_fvld  = 1;
        end
    end else if (m_active && m_cnt < SWEEP + 1) begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!m_active) begin
      chk("idle_stim", stim, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_tt", tt, 0);
      chk("idle_err", err_cnt, 0);
      chk("idle_pass", pass, 0);
`ifdef LAB_SCAN_FIRST_ERR_EN
      chk("idle_ferr", {first_err_vld, first_err}, 0);
`endif
    end else if (m_cnt < SWEEP) begin
      chk("sweep_busy", busy, 1);
      chk("sweep_done", done, 0);
      chk("sweep_stim", stim, m_cnt / (S + 1));
      chk("sweep_pass", pass, 0);
    end else begin
      chk("res_busy", busy, 0);
      chk("res_done", done, m_cnt == SWEEP);
      chk("res_stim", stim, (m_cnt == SWEEP) ? V - 1 : 0);
      chk("res_tt", tt, m_tt);
      chk("res_err", err_cnt, m_err);
      chk("res_pass", pass, m_err == 0);
`ifdef LAB_SCAN_FIRST_ERR_EN
      chk("res_ferr", {first_err_vld, first_err}, {m_fvld, m_first});
`endif
    end
  end

  task automatic pulse_and_wait(output int lat);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("done_latency", lat, SWEEP);
  endtask

  initial begin
    int lat;
    int dt[$];
    rst = 1'b1; start = 1'b0; exp_tt = '0; mode = 0; rtab = '0;
    start3 = 1'b0; exp3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stim", stim, 0);
    chk("rst_tt", tt, 0);
    chk("rst_pass", pass, 0);
    #1 rst = 1'b0;

    mode = 0; exp_tt = 16'hAAAA;
    pulse_and_wait(lat);
    chk("a_tt", tt, 16'hAAAA);
    chk("a_err", err_cnt, 0);
    chk("a_pass", pass, 1);

    exp_tt = 16'hAAAB;
    pulse_and_wait(lat);
    chk("b_err", err_cnt, 1);
    chk("b_pass", pass, 0);
`ifdef LAB_SCAN_FIRST_ERR_EN
    chk("b_ferr", {first_err_vld, first_err}, 5'h10);
`endif

    mode = 1; exp_tt = 16'hFFFF;
    pulse_and_wait(lat);
    chk("c_tt", tt, 0);
    chk("c_err", err_cnt, 5'b10000);
    chk("c_pass", pass, 0);
`ifdef LAB_SCAN_FIRST_ERR_EN
    chk("c_ferr", first_err, 0);
`endif

    mode = 0; exp_tt = 16'hAAAA;
    @(posedge clk); #2 start = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done) dt.push_back(i);
    end
    @(posedge clk); #2 start = 1'b0;
    chk("held_pulses", dt.size() >= 2, 1);
    for (int i = 1; i < dt.size(); i++) chk("held_period", dt[i] - dt[i-1], 50);
    for (int i = 0; i < 200 && (busy || done); i++) @(negedge clk);
    repeat (2) @(posedge clk);

    @(posedge clk); #2 start3 = 1'b1; exp3 = 8'hC0;
    @(posedge clk); #2 start3 = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      chk("n3_stim", stim3, e);
      chk("n3_busy", busy3, 1);
    end
    @(negedge clk);
    chk("n3_done", done3, 1);
    chk("n3_tt", tt3, 8'hC0);
    chk("n3_err", err3, 0);
    chk("n3_pass", pass3, 1);

    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_stim", stim, 0);
    chk("abort_tt", tt, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) lat++;
    end
    chk("abort_no_done", lat, 0);
    pulse_and_wait(lat);
    chk("abort_tt_after", tt, 16'hAAAA);

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      if (!m_active || m_cnt >= SWEEP) begin
        mode = $urandom_range(0, 2);
        rtab = V'($urandom);
      end
      case ($urandom_range(0, 2))
        0:       exp_tt = rtab;
        1:       exp_tt = rtab ^ (V'(1) << $urandom_range(0, V - 1));
        default: exp_tt = V'($urandom);
      endcase
      start = ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    repeat (60) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
